// File: rtl/pipeline_ctrl.sv
// Pipeline control sequencer for the 5-stage RISC-V core: carries decode controls
// through ID/EX, EX/MEM and MEM/WB, resolves hazards and counts stall/flush events.
module pipeline_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int ALU_CTRL_W = 3,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  RegWriteD,
  input  logic [1:0]            ResultSrcD,
  input  logic                  MemWriteD,
  input  logic                  JumpD,
  input  logic                  BranchD,
  input  logic                  ALUSrcD,
  input  logic [ALU_CTRL_W-1:0] ALUControlD,
  input  logic [REG_ADDR_W-1:0] Rs1D,
  input  logic [REG_ADDR_W-1:0] Rs2D,
  input  logic [REG_ADDR_W-1:0] RdD,
  input  logic                  ZeroE,
  output logic                  RegWriteE,
  output logic                  MemWriteE,
  output logic                  ALUSrcE,
  output logic [ALU_CTRL_W-1:0] ALUControlE,
  output logic                  RegWriteM,
  output logic                  MemWriteM,
  output logic [1:0]            ResultSrcW,
  output logic                  RegWriteW,
  output logic [REG_ADDR_W-1:0] RdW,
  output logic                  PCSrcE,
  output logic                  StallF,
  output logic                  StallD,
  output logic                  FlushD,
  output logic                  FlushE,
  output logic [1:0]            ForwardAE,
  output logic [1:0]            ForwardBE,
  output logic [CNT_W-1:0]      StallCount,
  output logic [CNT_W-1:0]      FlushCount
);

  localparam logic [1:0] RES_LOAD = 2'b01;
  localparam logic [1:0] FWD_RF   = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;

  typedef struct packed {
    logic                  reg_write;
    logic [1:0]            result_src;
    logic                  mem_write;
    logic                  jump;
    logic                  branch;
    logic                  alu_src;
    logic [ALU_CTRL_W-1:0] alu_control;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [REG_ADDR_W-1:0] rd;
  } idex_t;

  idex_t                 d_word;
  idex_t                 e_q;
  logic                  reg_write_m, mem_write_m;
  logic [1:0]            result_src_m;
  logic [REG_ADDR_W-1:0] rd_m;
  logic                  reg_write_w;
  logic [1:0]            result_src_w;
  logic [REG_ADDR_W-1:0] rd_w;
  logic                  lw_stall;

  always_comb begin
    d_word = '{reg_write:   RegWriteD,
               result_src:  ResultSrcD,
               mem_write:   MemWriteD,
               jump:        JumpD,
               branch:      BranchD,
               alu_src:     ALUSrcD,
               alu_control: ALUControlD,
               rs1:         Rs1D,
               rs2:         Rs2D,
               rd:          RdD};
  end

  // Hazard detection; x0 as a destination never stalls.
  assign PCSrcE   = (e_q.branch & ZeroE) | e_q.jump;
  assign lw_stall = (e_q.result_src == RES_LOAD) && (e_q.rd != '0) &&
                    ((Rs1D == e_q.rd) || (Rs2D == e_q.rd));
  assign StallF   = lw_stall & ~PCSrcE;
  assign StallD   = StallF;
  assign FlushD   = PCSrcE;
  assign FlushE   = lw_stall | PCSrcE;

  function automatic logic [1:0] fwd_sel(
    input logic [REG_ADDR_W-1:0] rs,
    input logic                  wr_m,
    input logic [REG_ADDR_W-1:0] dst_m,
    input logic                  wr_w,
    input logic [REG_ADDR_W-1:0] dst_w
  );
    if (wr_m && dst_m != '0 && rs == dst_m)      return FWD_MEM;
    else if (wr_w && dst_w != '0 && rs == dst_w) return FWD_WB;
    else                                         return FWD_RF;
  endfunction

  assign ForwardAE = fwd_sel(e_q.rs1, reg_write_m, rd_m, reg_write_w, rd_w);
  assign ForwardBE = fwd_sel(e_q.rs2, reg_write_m, rd_m, reg_write_w, rd_w);

  // A stall needs no ID/EX enable: FlushE is always asserted with it, so a
  // bubble enters EX while the front end holds the instruction in D.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    if (!rst_n)      e_q <= '0;
    else if (FlushE) e_q <= '0;
    else             e_q <= d_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_write_m  <= 1'b0;
      result_src_m <= '0;
      mem_write_m  <= 1'b0;
      rd_m         <= '0;
      reg_write_w  <= 1'b0;
      result_src_w <= '0;
      rd_w         <= '0;
    end else begin
      reg_write_m  <= e_q.reg_write;
      result_src_m <= e_q.result_src;
      mem_write_m  <= e_q.mem_write;
      rd_m         <= e_q.rd;
      reg_write_w  <= reg_write_m;
      result_src_w <= result_src_m;
      rd_w         <= rd_m;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      StallCount <= '0;
      FlushCount <= '0;
    end else begin
      if (StallF && StallCount != '1) StallCount <= StallCount + CNT_W'(1);
      if (FlushD && FlushCount != '1) FlushCount <= FlushCount + CNT_W'(1);
    end
  end

  assign RegWriteE   = e_q.reg_write;
  assign MemWriteE   = e_q.mem_write;
  assign ALUSrcE     = e_q.alu_src;
  assign ALUControlE = e_q.alu_control;
  assign RegWriteM   = reg_write_m;
  assign MemWriteM   = mem_write_m;
  assign ResultSrcW  = result_src_w;
  assign RegWriteW   = reg_write_w;
  assign RdW         = rd_w;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: a writeback scoreboard plus hazard, forwarding,
// flush, counter-saturation and asynchronous-reset checks.
module tb_pipeline_ctrl;

  logic       clk, rst_n;
  logic       RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD, ZeroE;
  logic [1:0] ResultSrcD;
  logic [2:0] ALUControlD;
  logic [4:0] Rs1D, Rs2D, RdD;

  logic        RegWriteE, MemWriteE, ALUSrcE, RegWriteM, MemWriteM, RegWriteW;
  logic [2:0]  ALUControlE;
  logic [1:0]  ResultSrcW, ForwardAE, ForwardBE;
  logic [4:0]  RdW;
  logic        PCSrcE, StallF, StallD, FlushD, FlushE;
  logic [15:0] StallCount, FlushCount;

  logic       s_RegWriteE, s_MemWriteE, s_ALUSrcE, s_RegWriteM, s_MemWriteM, s_RegWriteW;
  logic [2:0] s_ALUControlE;
  logic [1:0] s_ResultSrcW, s_ForwardAE, s_ForwardBE;
  logic [4:0] s_RdW;
  logic       s_PCSrcE, s_StallF, s_StallD, s_FlushD, s_FlushE;
  logic [1:0] s_StallCount, s_FlushCount;

  pipeline_ctrl dut (
    .clk(clk), .rst_n(rst_n), .RegWriteD(RegWriteD), .ResultSrcD(ResultSrcD),
    .MemWriteD(MemWriteD), .JumpD(JumpD), .BranchD(BranchD), .ALUSrcD(ALUSrcD),
    .ALUControlD(ALUControlD), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .ZeroE(ZeroE),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ALUSrcE(ALUSrcE),
    .ALUControlE(ALUControlE), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
    .ResultSrcW(ResultSrcW), .RegWriteW(RegWriteW), .RdW(RdW), .PCSrcE(PCSrcE),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallCount(StallCount), .FlushCount(FlushCount)
  );

  // Narrow-counter copy driven by the same stimulus, for saturation.
  pipeline_ctrl #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .RegWriteD(RegWriteD), .ResultSrcD(ResultSrcD),
    .MemWriteD(MemWriteD), .JumpD(JumpD), .BranchD(BranchD), .ALUSrcD(ALUSrcD),
    .ALUControlD(ALUControlD), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .ZeroE(ZeroE),
    .RegWriteE(s_RegWriteE), .MemWriteE(s_MemWriteE), .ALUSrcE(s_ALUSrcE),
    .ALUControlE(s_ALUControlE), .RegWriteM(s_RegWriteM), .MemWriteM(s_MemWriteM),
    .ResultSrcW(s_ResultSrcW), .RegWriteW(s_RegWriteW), .RdW(s_RdW), .PCSrcE(s_PCSrcE),
    .StallF(s_StallF), .StallD(s_StallD), .FlushD(s_FlushD), .FlushE(s_FlushE),
    .ForwardAE(s_ForwardAE), .ForwardBE(s_ForwardBE),
    .StallCount(s_StallCount), .FlushCount(s_FlushCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       rw;
    logic [1:0] rs;
    logic [4:0] rd;
  } wb_t;

  wb_t wb_q[$];
  int  checks = 0;
  int  errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_d(input logic rw, input logic [1:0] rs, input logic mw, input logic j,
                       input logic b, input logic as, input logic [2:0] alu,
                       input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd);
    RegWriteD = rw; ResultSrcD = rs; MemWriteD = mw; JumpD = j; BranchD = b;
    ALUSrcD = as; ALUControlD = alu; Rs1D = r1; Rs2D = r2; RdD = rd;
  endtask

  task automatic nop();
    set_d(0, 2'b00, 0, 0, 0, 0, 3'd0, 5'd0, 5'd0, 5'd0);
  endtask

  // One clock: the word in D (or a bubble, if a flush is expected) enters the
  // scoreboard and is compared at writeback three edges later.
  task automatic cyc(input logic bubble);
    wb_t e;
    e = bubble ? '0 : wb_t'{RegWriteD, ResultSrcD, RdD};
    wb_q.push_back(e);
    @(posedge clk); #1;
    if (wb_q.size() == 3) begin
      e = wb_q.pop_front();
      check("wb_regwrite", RegWriteW, e.rw);
      check("wb_resultsrc", ResultSrcW, e.rs);
      check("wb_rd", RdW, e.rd);
    end
  endtask

  initial begin
    rst_n = 1'b0; ZeroE = 1'b0;
    nop();
    #3;
    check("rst_regwrite_e", RegWriteE, 0);
    check("rst_regwrite_w", RegWriteW, 0);
    check("rst_stallcount", StallCount, 0);
    check("rst_flushcount", FlushCount, 0);
    check("rst_forward_a", ForwardAE, 0);
    @(posedge clk); #2 rst_n = 1'b1;

    // Latency of an ALU op and a store through the stages.
    set_d(1, 2'b00, 0, 0, 0, 0, 3'b101, 5'd1, 5'd2, 5'd5);
    cyc(0);
    check("lat_regwrite_e", RegWriteE, 1);
    check("lat_aluctrl_e", ALUControlE, 3'b101);
    check("lat_regwrite_m_early", RegWriteM, 0);
    set_d(0, 2'b00, 1, 0, 0, 1, 3'b000, 5'd1, 5'd2, 5'd0);
    cyc(0);
    check("lat_regwrite_m", RegWriteM, 1);
    check("sw_memwrite_e", MemWriteE, 1);
    check("sw_alusrc_e", ALUSrcE, 1);
    nop();
    cyc(0);
    check("lat_regwrite_w", RegWriteW, 1);
    check("lat_rd_w", RdW, 5);
    check("sw_memwrite_m", MemWriteM, 1);
    cyc(0); cyc(0);

    // Load-use: lw x6 then add x8, x6, x3.
    set_d(1, 2'b01, 0, 0, 0, 1, 3'b000, 5'd1, 5'd0, 5'd6);
    cyc(0);
    set_d(1, 2'b00, 0, 0, 0, 0, 3'b000, 5'd6, 5'd3, 5'd8);
    #1;
    check("lu_stallf", StallF, 1);
    check("lu_stalld", StallD, 1);
    check("lu_flushe", FlushE, 1);
    check("lu_flushd", FlushD, 0);
    cyc(1);
    check("lu_bubble_e", RegWriteE, 0);
    check("lu_stall_released", StallF, 0);
    cyc(0);
    check("lu_fwd_a", ForwardAE, 2'b01);
    check("lu_fwd_b", ForwardBE, 2'b00);
    check("lu_stallcount", StallCount, 1);

    // Forwarding priority: MEM over WB, then WB only.
    set_d(1, 2'b00, 0, 0, 0, 0, 3'b000, 5'd1, 5'd2, 5'd7);
    cyc(0);
    set_d(1, 2'b00, 0, 0, 0, 0, 3'b000, 5'd3, 5'd4, 5'd7);
    cyc(0);
    set_d(1, 2'b00, 0, 0, 0, 0, 3'b001, 5'd7, 5'd7, 5'd9);
    cyc(0);
    check("fwd_a_mem", ForwardAE, 2'b10);
    check("fwd_b_mem", ForwardBE, 2'b10);
    set_d(1, 2'b00, 0, 0, 0, 0, 3'b011, 5'd7, 5'd5, 5'd10);
    cyc(0);
    check("fwd_a_wb", ForwardAE, 2'b01);
    check("fwd_b_none", ForwardBE, 2'b00);

    // Same pattern targeting x0: never forwarded.
    set_d(1, 2'b00, 0, 0, 0, 0, 3'b000, 5'd1, 5'd2, 5'd0);
    cyc(0);
    set_d(1, 2'b00, 0, 0, 0, 0, 3'b000, 5'd3, 5'd4, 5'd0);
    cyc(0);
    set_d(1, 2'b00, 0, 0, 0, 0, 3'b001, 5'd0, 5'd0, 5'd9);
    cyc(0);
    check("fwd_a_x0", ForwardAE, 2'b00);
    check("fwd_b_x0", ForwardBE, 2'b00);
    nop();
    cyc(0); cyc(0);

    // Taken branch.
    set_d(0, 2'b00, 0, 0, 1, 0, 3'b001, 5'd1, 5'd2, 5'd0);
    cyc(0);
    ZeroE = 1'b1;
    set_d(1, 2'b00, 0, 0, 0, 0, 3'b000, 5'd1, 5'd2, 5'd11);
    #1;
    check("br_pcsrc", PCSrcE, 1);
    check("br_flushd", FlushD, 1);
    check("br_flushe", FlushE, 1);
    check("br_no_stall", StallF, 0);
    cyc(1);
    check("br_bubble_e", RegWriteE, 0);
    check("br_pcsrc_after", PCSrcE, 0);
    check("br_flushcount", FlushCount, 1);

    // Untaken branch.
    set_d(0, 2'b00, 0, 0, 1, 0, 3'b001, 5'd1, 5'd2, 5'd0);
    cyc(0);
    ZeroE = 1'b0;
    set_d(1, 2'b00, 0, 0, 0, 0, 3'b000, 5'd1, 5'd2, 5'd11);
    #1;
    check("nbr_pcsrc", PCSrcE, 0);
    check("nbr_flushe", FlushE, 0);
    cyc(0);
    check("nbr_regwrite_e", RegWriteE, 1);
    check("nbr_flushcount", FlushCount, 1);

    // Jump flushes regardless of ZeroE.
    set_d(1, 2'b10, 0, 1, 0, 0, 3'b000, 5'd0, 5'd0, 5'd1);
    cyc(0);
    set_d(1, 2'b00, 0, 0, 0, 0, 3'b000, 5'd1, 5'd2, 5'd12);
    #1;
    check("jmp_pcsrc", PCSrcE, 1);
    check("jmp_flushe", FlushE, 1);
    cyc(1);
    check("jmp_flushcount", FlushCount, 2);

    // Load-use and redirect together: the redirect wins, no stall.
    set_d(1, 2'b01, 0, 1, 0, 0, 3'b000, 5'd0, 5'd0, 5'd13);
    cyc(0);
    set_d(1, 2'b00, 0, 0, 0, 0, 3'b000, 5'd13, 5'd0, 5'd14);
    #1;
    check("both_stallf", StallF, 0);
    check("both_flushe", FlushE, 1);
    check("both_flushd", FlushD, 1);
    cyc(1);
    check("both_stallcount", StallCount, 1);
    check("both_flushcount", FlushCount, 3);

    // Five more load-use stalls; the 2-bit counter saturates at 3.
    for (int i = 0; i < 5; i++) begin
      set_d(1, 2'b01, 0, 0, 0, 1, 3'b000, 5'd1, 5'd0, 5'd6);
      cyc(0);
      set_d(1, 2'b00, 0, 0, 0, 0, 3'b000, 5'd2, 5'd6, 5'd8);
      cyc(1);
      cyc(0);
    end
    check("sat_stallcount_wide", StallCount, 6);
    check("sat_stallcount_narrow", s_StallCount, 3);
    check("sat_flushcount_narrow", s_FlushCount, 3);

    // Asynchronous reset mid-stream, then refill.
    set_d(1, 2'b00, 0, 0, 0, 0, 3'b000, 5'd1, 5'd2, 5'd5);
    cyc(0); cyc(0);
    #2 rst_n = 1'b0;
    #1;
    check("mrst_regwrite_e", RegWriteE, 0);
    check("mrst_regwrite_m", RegWriteM, 0);
    check("mrst_regwrite_w", RegWriteW, 0);
    check("mrst_rd_w", RdW, 0);
    check("mrst_stallcount", StallCount, 0);
    check("mrst_flushcount", FlushCount, 0);
    check("mrst_stallcount_narrow", s_StallCount, 0);
    wb_q.delete();
    @(posedge clk); #2 rst_n = 1'b1;
    cyc(0);
    check("refill_regwrite_e", RegWriteE, 1);
    cyc(0);
    check("refill_w_not_yet", RegWriteW, 0);
    cyc(0);
    check("refill_regwrite_w", RegWriteW, 1);
    nop();
    cyc(0); cyc(0); cyc(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Pipeline sequencer for the 5-stage RISC-V core. It takes the decode-stage control word from control_unit and carries it through the ID/EX, EX/MEM and MEM/WB control registers. It resolves hazards: load-use stall, branch/jump flush, and EX-stage operand forwarding selects. It also keeps saturating stall and flush performance counters.

Parameters:
REG_ADDR_W, 5, register-file address width (x0..x31)
ALU_CTRL_W, 3, ALUControl width, matching control_unit
CNT_W, 16, width of each performance counter

Ports:
clk  in  1  core clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
RegWriteD  in  1  decode-stage RegWrite from control_unit
ResultSrcD  in  2  00=ALU, 01=memory load, 10=PC+4
MemWriteD  in  1  decode-stage MemWrite
JumpD  in  1  decode-stage Jump
BranchD  in  1  decode-stage Branch
ALUSrcD  in  1  decode-stage ALUSrc
ALUControlD  in  ALU_CTRL_W  decode-stage ALUControl
Rs1D, Rs2D, RdD  in  REG_ADDR_W each  decode-stage register fields
ZeroE  in  1  ALU zero flag, execute stage
RegWriteE, MemWriteE, ALUSrcE  out  1 each  ID/EX controls
ALUControlE  out  ALU_CTRL_W  ID/EX ALU control
RegWriteM, MemWriteM  out  1 each  EX/MEM controls
ResultSrcW  out  2  MEM/WB result select
RegWriteW  out  1  MEM/WB register write enable
RdW  out  REG_ADDR_W  writeback destination register
PCSrcE  out  1  take branch/jump target
StallF, StallD  out  1 each  hold PC and IF/ID register
FlushD, FlushE  out  1 each  bubble IF/ID and ID/EX on next edge
ForwardAE, ForwardBE  out  2 each  00=regfile, 01=WB result, 10=MEM ALU result
StallCount, FlushCount  out  CNT_W each  saturating event counters

Behaviour:
- Reset (rst_n=0, asynchronous, any cycle): every pipeline register, including Rs1E/Rs2E/RdE/RdM/RdW and ResultSrcE/M/W, clears to 0.
  - Counters clear to 0.
  - All outputs read 0 while reset is held.
  - Reset mid-operation discards in-flight controls with no partial state.
- Internal stage registers:
  - ID/EX: RegWrite, ResultSrc, MemWrite, Jump, Branch, ALUSrc, ALUControl, Rs1, Rs2, Rd.
  - EX/MEM: RegWrite, ResultSrc, MemWrite, Rd.
  - MEM/WB: RegWrite, ResultSrc, Rd.
- Latency: a D-stage control word appears on E outputs 1 cycle later, M 2 cycles later, W 3 cycles later.
- PCSrcE = (BranchE & ZeroE) | JumpE. Combinational.
- lwStall = (ResultSrcE==01) & (RdE!=0) & ((Rs1D==RdE) | (Rs2D==RdE)). Combinational.
- StallF = StallD = lwStall & ~PCSrcE.
  - The two cannot coincide legally, since the E instruction is either a load or a branch/jump.
  - PCSrcE still wins, for robustness.
- FlushD = PCSrcE.
- FlushE = lwStall | PCSrcE.
  - When FlushE=1, the next edge loads all ID/EX fields with 0 (a bubble) instead of the D inputs.
  - EX/MEM and MEM/WB still advance.
- No stall ever freezes EX/MEM or MEM/WB; they advance every cycle.
- ForwardAE:
  - 10 if RegWriteM & RdM!=0 & Rs1E==RdM;
  - else 01 if RegWriteW & RdW!=0 & Rs1E==RdW;
  - else 00.
  - MEM has priority over WB. ForwardBE uses the same rules with Rs2E.
- x0 is never forwarded and never causes a stall.
- StallCount increments by 1 on each edge where StallF=1. FlushCount increments on each edge where FlushD=1.
  - Both saturate at 2^CNT_W-1 with no wrap.

Test Plan:
- Reset: pulse rst_n low mid-stream with RegWriteD=1 -> all outputs 0 immediately (asynchronous), counters 0; pipeline refills 3 cycles after release.
- Latency: issue add x5 (RegWriteD=1, ResultSrcD=00, RdD=5) -> RegWriteE=1 at cycle+1, RegWriteM=1 at +2, RegWriteW=1 with RdW=5 at +3.
- Load-use: lw x6 followed by add with Rs1D=6 -> StallF=StallD=FlushE=1 for exactly 1 cycle, ID/EX bubble (RegWriteE=0), then ForwardAE=01 for the add in E; StallCount=1.
- Forwarding priority: add x7, add x7, then sub with Rs1=Rs2=7 -> ForwardAE=ForwardBE=10 (MEM wins over WB). Repeat with Rd=0 -> both 00.
- Branch: BranchE=1, ZeroE=1 -> PCSrcE=FlushD=FlushE=1, next ID/EX zeroed, FlushCount+1. With ZeroE=0 -> no flush. With JumpE=1 -> flush regardless of ZeroE.
- Saturation: CNT_W=2, force 5 load-use stalls -> StallCount holds 3.
